packed_dot_engine: RTL and testbench

- Second-generation compute block between the input SRAM, the weight memory and the output SRAM.
- On a `dut_run` request it reads a 2-word header from each memory: word 0 is the element count, word 1 is the element width in bits.
- It then streams the packed signed elements from both memories, multiply-accumulates them with one memory word per cycle, and writes the 32-bit dot product to the output SRAM as two words.
- Element width (2/4/8/16) is selected at run time from the header. Error detection and a done pulse are new in this generation.

---
 rtl/packed_dot_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_packed_dot_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packed_dot_engine.sv
// packed_dot_engine: reads a two-word header from the input SRAM and from the
// weight memory. It then multiply-accumulates the packed signed elements, one
// memory word per cycle, and writes the 32-bit dot product to the output SRAM
// as a low word followed by a high word.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for dut_run
// HDR    | two cycles: issue header addresses, capture element counts
// LOAD   | capture element sizes, validate header, size the word loop
// CALC   | accumulate one data word per cycle, words_left down to 1
// WR_LO  | write result[15:0] to OUT_BASE (suppressed on bad header)
// WR_HI  | write result[31:16] to OUT_BASE+1 (suppressed on bad header)
// DONE   | one-cycle done pulse, error flag becomes visible
module packed_dot_engine #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 12,
   parameter int ACC_W    = 32,
   parameter int IN_BASE  = 0,
   parameter int WT_BASE  = 0,
   parameter int OUT_BASE = 0,
   parameter int MAX_N    = 4095
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dut_run,
   output logic              dut_busy,
   output logic              dut_done,
   output logic              dut_error,
   output logic [ADDR_W-1:0] dut_sram_read_address,
   input  logic [DATA_W-1:0] sram_dut_read_data,
   output logic [ADDR_W-1:0] dut_wmem_read_address,
   input  logic [DATA_W-1:0] wmem_dut_read_data,
   output logic [ADDR_W-1:0] dut_sram_write_address,
   output logic [DATA_W-1:0] dut_sram_write_data,
   output logic              dut_sram_write_enable
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_CALC  = 3'd3;
   localparam logic [2:0] S_WR_LO = 3'd4;
   localparam logic [2:0] S_WR_HI = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]               state;
   logic                     hdr_phase;
   logic [15:0]              in_cnt;
   logic [15:0]              wt_cnt;
   logic [4:0]               in_size;
   logic [15:0]              words_left;
   logic [15:0]              elems_left;
   logic signed [ACC_W-1:0]  acc;
   logic                     hdr_bad;
   logic                     err;
   logic [ADDR_W-1:0]        sram_addr;
   logic [ADDR_W-1:0]        wmem_addr;

   logic                     size_ok;
   logic                     hdr_bad_c;
   logic [15:0]              w_words_c;
   logic [16:0]              cnt_ext;
   logic [15:0]              lanes;
   logic signed [ACC_W-1:0]  word_sum;
   logic signed [31:0]       result;

   // Header validation and word count, evaluated while the size words are on the read buses
   always_comb begin
      cnt_ext   = {1'b0, in_cnt};
      size_ok   = 1'b0;
      w_words_c = '0;
      case (sram_dut_read_data)
         16'd2: begin
            size_ok   = 1'b1;
            w_words_c = 16'((cnt_ext + 17'd7) >> 3);
         end
         16'd4: begin
            size_ok   = 1'b1;
            w_words_c = 16'((cnt_ext + 17'd3) >> 2);
         end
         16'd8: begin
            size_ok   = 1'b1;
            w_words_c = 16'((cnt_ext + 17'd1) >> 1);
         end
         16'd16: begin
            size_ok   = 1'b1;
            w_words_c = in_cnt;
         end
         default: begin
            size_ok   = 1'b0;
            w_words_c = '0;
         end
      endcase
      hdr_bad_c = !size_ok
                  || (sram_dut_read_data != wmem_dut_read_data)
                  || (in_cnt != wt_cnt)
                  || (in_cnt > 16'(MAX_N));
   end

   // Elements per word for the captured size
   always_comb begin
      case (in_size)
         5'd2:    lanes = 16'd8;
         5'd4:    lanes = 16'd4;
         5'd8:    lanes = 16'd2;
         default: lanes = 16'd1;
      endcase
   end

   // Sum of lane products for the current word; lanes at or beyond the element count contribute zero
   always_comb begin
      word_sum = '0;
      case (in_size)
         5'd2: begin
            for (int j = 0; j < 8; j++) begin
               if (16'(j) < elems_left)
                  word_sum = word_sum
                     + ACC_W'($signed(sram_dut_read_data[2*j +: 2]))
                     * ACC_W'($signed(wmem_dut_read_data[2*j +: 2]));
            end
         end
         5'd4: begin
            for (int j = 0; j < 4; j++) begin
               if (16'(j) < elems_left)
                  word_sum = word_sum
                     + ACC_W'($signed(sram_dut_read_data[4*j +: 4]))
                     * ACC_W'($signed(wmem_dut_read_data[4*j +: 4]));
            end
         end
         5'd8: begin
            for (int j = 0; j < 2; j++) begin
               if (16'(j) < elems_left)
                  word_sum = word_sum
                     + ACC_W'($signed(sram_dut_read_data[8*j +: 8]))
                     * ACC_W'($signed(wmem_dut_read_data[8*j +: 8]));
            end
         end
         default: begin
            if (elems_left != 16'd0)
               word_sum = ACC_W'($signed(sram_dut_read_data))
                        * ACC_W'($signed(wmem_dut_read_data));
         end
      endcase
   end

   // Sequencer, address generation and accumulator
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         hdr_phase  <= 1'b0;
         in_cnt     <= '0;
         wt_cnt     <= '0;
         in_size    <= '0;
         words_left <= '0;
         elems_left <= '0;
         acc        <= '0;
         hdr_bad    <= 1'b0;
         err        <= 1'b0;
         sram_addr  <= '0;
         wmem_addr  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (dut_run) begin
                  state     <= S_HDR;
                  hdr_phase <= 1'b0;
                  sram_addr <= ADDR_W'(IN_BASE);
                  wmem_addr <= ADDR_W'(WT_BASE);
                  acc       <= '0;
                  hdr_bad   <= 1'b0;
                  err       <= 1'b0;
               end
            end
            S_HDR: begin
               sram_addr <= sram_addr + 1'b1;
               wmem_addr <= wmem_addr + 1'b1;
               if (!hdr_phase) begin
                  hdr_phase <= 1'b1;
               end else begin
                  in_cnt <= sram_dut_read_data;
                  wt_cnt <= wmem_dut_read_data;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               // The first data address goes out here; it is wasted when the loop is skipped
               sram_addr  <= sram_addr + 1'b1;
               wmem_addr  <= wmem_addr + 1'b1;
               in_size    <= sram_dut_read_data[4:0];
               hdr_bad    <= hdr_bad_c;
               words_left <= w_words_c;
               elems_left <= in_cnt;
               // A bad header rides the write states with the strobe held low so that
               // done lands at the same offset as an empty job
               if (hdr_bad_c || (w_words_c == 16'd0))
                  state <= S_WR_LO;
               else
                  state <= S_CALC;
            end
            S_CALC: begin
               sram_addr  <= sram_addr + 1'b1;
               wmem_addr  <= wmem_addr + 1'b1;
               acc        <= acc + word_sum;
               elems_left <= elems_left - lanes;
               words_left <= words_left - 1'b1;
               if (words_left == 16'd1)
                  state <= S_WR_LO;
            end
            S_WR_LO: begin
               state <= S_WR_HI;
            end
            S_WR_HI: begin
               state <= S_DONE;
               err   <= hdr_bad;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign result = 32'(acc);

   // Output drive decoded from state; write path is idle outside the write states
   always_comb begin
      dut_sram_write_enable  = 1'b0;
      dut_sram_write_address = '0;
      dut_sram_write_data    = '0;
      if (!hdr_bad) begin
         if (state == S_WR_LO) begin
            dut_sram_write_enable  = 1'b1;
            dut_sram_write_address = ADDR_W'(OUT_BASE);
            dut_sram_write_data    = DATA_W'(result[15:0]);
         end else if (state == S_WR_HI) begin
            dut_sram_write_enable  = 1'b1;
            dut_sram_write_address = ADDR_W'(OUT_BASE + 1);
            dut_sram_write_data    = DATA_W'(result[31:16]);
         end
      end
   end

   assign dut_busy              = (state != S_IDLE) && (state != S_DONE);
   assign dut_done              = (state == S_DONE);
   assign dut_error             = err;
   assign dut_sram_read_address = sram_addr;
   assign dut_wmem_read_address = wmem_addr;

endmodule

// File: tb/tb_packed_dot_engine.sv
// Bench for packed_dot_engine: behavioural memories, an element-level dot
// product model, and a per-cycle timeline check of every job.
module tb_packed_dot_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        dut_run;
   logic        dut_busy;
   logic        dut_done;
   logic        dut_error;
   logic [11:0] dut_sram_read_address;
   logic [15:0] sram_dut_read_data;
   logic [11:0] dut_wmem_read_address;
   logic [15:0] wmem_dut_read_data;
   logic [11:0] dut_sram_write_address;
   logic [15:0] dut_sram_write_data;
   logic        dut_sram_write_enable;

   logic [15:0] isram  [0:63];
   logic [15:0] wmem   [0:63];
   logic [15:0] outmem [0:63];
   int          nwrites = 0;

   int checks = 0;
   int passes = 0;

   packed_dot_engine dut (
      .clk                    (clk),
      .reset                  (reset),
      .dut_run                (dut_run),
      .dut_busy               (dut_busy),
      .dut_done               (dut_done),
      .dut_error              (dut_error),
      .dut_sram_read_address  (dut_sram_read_address),
      .sram_dut_read_data     (sram_dut_read_data),
      .dut_wmem_read_address  (dut_wmem_read_address),
      .wmem_dut_read_data     (wmem_dut_read_data),
      .dut_sram_write_address (dut_sram_write_address),
      .dut_sram_write_data    (dut_sram_write_data),
      .dut_sram_write_enable  (dut_sram_write_enable)
   );

   always #5 clk = ~clk;

   // Synchronous-read memories and the output write log
   always @(posedge clk) begin
      sram_dut_read_data <= isram[dut_sram_read_address[5:0]];
      wmem_dut_read_data <= wmem[dut_wmem_read_address[5:0]];
      if (dut_sram_write_enable) begin
         outmem[dut_sram_write_address[5:0]] <= dut_sram_write_data;
         nwrites <= nwrites + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   function automatic int elem(input logic [15:0] word, input int sh, input int sz);
      int x;
      x = int'(word >> sh) & ((1 << sz) - 1);
      if (x >= (1 << (sz - 1))) x -= (1 << sz);
      return x;
   endfunction

   // Dot product straight from the memory contents, element by element
   task automatic model(output logic [31:0] res, output bit bad, output int w);
      int n, sz, lanes, acc, wi, sh;
      n   = int'(isram[0]);
      sz  = int'(isram[1]);
      bad = !(sz == 2 || sz == 4 || sz == 8 || sz == 16) || (isram[1] != wmem[1])
            || (isram[0] != wmem[0]) || (n > 4095);
      acc = 0;
      w   = 0;
      if (!bad) begin
         lanes = 16 / sz;
         w     = (n + lanes - 1) / lanes;
         for (int e = 0; e < n; e++) begin
            wi  = 2 + e / lanes;
            sh  = (e % lanes) * sz;
            acc += elem(isram[wi], sh, sz) * elem(wmem[wi], sh, sz);
         end
      end
      res = acc;
   endtask

   task automatic set_hdr(input int ni, input int si, input int nw, input int sw);
      isram[0] = 16'(ni);
      isram[1] = 16'(si);
      wmem[0]  = 16'(nw);
      wmem[1]  = 16'(sw);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_z_busy"}, 32'(dut_busy), 0);
      chk({tag, "_z_done"}, 32'(dut_done), 0);
      chk({tag, "_z_err"},  32'(dut_error), 0);
      chk({tag, "_z_we"},   32'(dut_sram_write_enable), 0);
      chk({tag, "_z_wa"},   32'(dut_sram_write_address), 0);
      chk({tag, "_z_wd"},   32'(dut_sram_write_data), 0);
      chk({tag, "_z_ra"},   32'(dut_sram_read_address), 0);
      chk({tag, "_z_wma"},  32'(dut_wmem_read_address), 0);
   endtask

   // One job: run pulse, then check every cycle T+1 .. T+last+1 against the model timeline
   task automatic run_job(input string tag, input int pulse_at, input int reset_at);
      logic [31:0] res;
      bit          bad;
      int          w, last, n0;
      bit          exp_we;
      model(res, bad, w);
      last = 6 + w;
      n0   = nwrites;
      @(negedge clk);
      dut_run = 1'b1;
      for (int c = 1; c <= last + 1; c++) begin
         @(negedge clk);
         dut_run = (c == pulse_at);
         if (reset_at != 0 && c == reset_at + 1) begin
            chk_all_zero(tag);
            reset = 1'b0;
            for (int k = 0; k < 30; k++) begin
               @(negedge clk);
               chk({tag, "_post_we"},   32'(dut_sram_write_enable), 0);
               chk({tag, "_post_busy"}, 32'(dut_busy), 0);
               chk({tag, "_post_done"}, 32'(dut_done), 0);
            end
            chk({tag, "_post_writes"}, 32'(nwrites - n0), 0);
            return;
         end
         exp_we = !bad && (c == last - 2 || c == last - 1);
         chk($sformatf("%s_busy_c%0d", tag, c), 32'(dut_busy), 32'(c < last));
         chk($sformatf("%s_done_c%0d", tag, c), 32'(dut_done), 32'(c == last));
         chk($sformatf("%s_we_c%0d", tag, c), 32'(dut_sram_write_enable), 32'(exp_we));
         chk($sformatf("%s_err_c%0d", tag, c), 32'(dut_error), 32'((c >= last) && bad));
         if (exp_we) begin
            chk($sformatf("%s_wa_c%0d", tag, c), 32'(dut_sram_write_address),
                (c == last - 2) ? 32'd0 : 32'd1);
            chk($sformatf("%s_wd_c%0d", tag, c), 32'(dut_sram_write_data),
                (c == last - 2) ? {16'd0, res[15:0]} : {16'd0, res[31:16]});
         end
         if (c == reset_at) reset = 1'b1;
      end
      chk({tag, "_nwrites"}, 32'(nwrites - n0), bad ? 32'd0 : 32'd2);
      if (!bad) begin
         chk({tag, "_out_lo"}, {16'd0, outmem[0]}, {16'd0, res[15:0]});
         chk({tag, "_out_hi"}, {16'd0, outmem[1]}, {16'd0, res[31:16]});
      end
   endtask

   task automatic load_t1();
      set_hdr(3, 8, 3, 8);
      isram[2] = 16'h0203; isram[3] = 16'h00FF;
      wmem[2]  = 16'h0405; wmem[3]  = 16'h0007;
   endtask

   initial begin
      logic [31:0] mres;
      bit          mbad;
      int          mw;

      for (int i = 0; i < 64; i++) begin
         isram[i] = '0;
         wmem[i]  = '0;
      end
      reset   = 1'b1;
      dut_run = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;

      // Size 8, N=3: 3*5 + 2*4 + (-1)*7 = 16, done at T+8
      load_t1();
      model(mres, mbad, mw);
      chk("t1_model_res", mres, 32'h0000_0010);
      chk("t1_model_w", 32'(mw), 32'd2);
      run_job("t1", 0, 0);
      chk("t1_lit_lo", {16'd0, outmem[0]}, 32'h0010);
      chk("t1_lit_hi", {16'd0, outmem[1]}, 32'h0000);

      // Size 2, N=8: eight (-1)*1 products
      set_hdr(8, 2, 8, 2);
      isram[2] = 16'hFFFF; wmem[2] = 16'h5555;
      model(mres, mbad, mw);
      chk("t2_model_res", mres, 32'hFFFF_FFF8);
      run_job("t2", 0, 0);
      chk("t2_lit_lo", {16'd0, outmem[0]}, 32'hFFF8);
      chk("t2_lit_hi", {16'd0, outmem[1]}, 32'hFFFF);

      // Size mismatch: no writes, error with done at T+6
      set_hdr(4, 4, 4, 8);
      model(mres, mbad, mw);
      chk("t3_model_bad", 32'(mbad), 32'd1);
      run_job("t3", 0, 0);

      // Size 16, N=2 with a run pulse inside CALC; also clears the error
      set_hdr(2, 16, 2, 16);
      isram[2] = 16'h7FFF; isram[3] = 16'h7FFF;
      wmem[2]  = 16'h7FFF; wmem[3]  = 16'h7FFF;
      model(mres, mbad, mw);
      chk("t4_model_res", mres, 32'h7FFE_0002);
      run_job("t4", 4, 0);
      chk("t4_lit_lo", {16'd0, outmem[0]}, 32'h0002);
      chk("t4_lit_hi", {16'd0, outmem[1]}, 32'h7FFE);

      // Reset at T+4 of a 20-word job, then a clean job
      set_hdr(20, 16, 20, 16);
      for (int i = 0; i < 20; i++) begin
         isram[2+i] = 16'(i * 1234 + 77);
         wmem[2+i]  = 16'(16'hF000 + i * 311);
      end
      run_job("t5", 0, 4);
      load_t1();
      run_job("t5b", 0, 0);

      // N=0, size 8: zero result written, done at T+6
      set_hdr(0, 8, 0, 8);
      model(mres, mbad, mw);
      chk("t6_model_w", 32'(mw), 32'd0);
      run_job("t6", 0, 0);

      // Size 4, N=5 with junk in the masked upper lanes of the last word
      set_hdr(5, 4, 5, 4);
      isram[2] = 16'h8F21; isram[3] = 16'hABC9;
      wmem[2]  = 16'h7E3D; wmem[3]  = 16'h5552;
      model(mres, mbad, mw);
      // (1*-3) + (2*3) + (-1*-2) + (-8*7) + (-7*2) = -65
      chk("t7_model_res", mres, 32'hFFFF_FFBF);
      run_job("t7", 0, 0);

      // Count mismatch and over-limit count both flag errors
      set_hdr(3, 8, 4, 8);
      run_job("t8", 0, 0);
      set_hdr(4096, 8, 4096, 8);
      run_job("t9", 0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
